// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared divide-ratio defaults and duty-cycle helper
package clkdiv_pkg;

   localparam int MCLK_DIV_DEFAULT = 4;
   localparam int AUX_DIV_DEFAULT  = 50_000_000;

   // Number of high cycles per period; odd ratios get the extra cycle high
   function automatic int high_cycles(input int div);
      return (div + 1) / 2;
   endfunction

endpackage

// File: rtl/clkdiv_stage.sv
// clkdiv_stage: one registered divide-by-DIV clock with ceil(DIV/2) high cycles
module clkdiv_stage
   import clkdiv_pkg::*;
#(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic rst,
   output logic out
);

   localparam int W = $clog2(DIV);
   localparam logic [W-1:0] H    = W'(high_cycles(DIV));
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   if (DIV < 2) begin : g_bad_div
      $error("clkdiv_stage: DIV must be at least 2, got %0d", DIV);
   end

   // Power-up values match the reset values
   logic [W-1:0] cnt = '0;
   logic         q   = 1'b0;

   // Phase counter and output flop; output decoded from the pre-increment count
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt <= '0;
         q   <= 1'b0;
      end else begin
         q   <= cnt < H;
         cnt <= cnt == LAST ? '0 : cnt + W'(1);
      end

   assign out = q;

endmodule

// File: rtl/clkdiv.sv
// clkdiv: derives mclk and aux_clk from clk with two independent divider stages
module clkdiv
   import clkdiv_pkg::*;
#(
   parameter int MCLK_DIV = MCLK_DIV_DEFAULT,
   parameter int AUX_DIV  = AUX_DIV_DEFAULT
) (
   input  logic rst,
   input  logic clk,
   output logic mclk,
   output logic aux_clk
);

   // Both stages share clk and rst so they leave reset on the same edge
   clkdiv_stage #(.DIV(MCLK_DIV)) u_mclk (
      .clk (clk),
      .rst (rst),
      .out (mclk)
   );

   clkdiv_stage #(.DIV(AUX_DIV)) u_aux (
      .clk (clk),
      .rst (rst),
      .out (aux_clk)
   );

endmodule

// File: tb/tb_clkdiv.sv
// tb_clkdiv: randomized reset/run sequences checked against an edge-count model
module tb_clkdiv;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mclk4, aux8, mclk5, aux10;

   int vectors     = 0;
   int miscompares = 0;
   int n           = 0;

   clkdiv #(.MCLK_DIV(4), .AUX_DIV(8)) u_dut4 (
      .rst     (rst),
      .clk     (clk),
      .mclk    (mclk4),
      .aux_clk (aux8)
   );

   clkdiv #(.MCLK_DIV(5), .AUX_DIV(10)) u_dut5 (
      .rst     (rst),
      .clk     (clk),
      .mclk    (mclk5),
      .aux_clk (aux10)
   );

   always #5 clk = ~clk;

   // Expected level after the n-th rising edge since reset release:
   // the period is div edges, of which the first ceil(div/2) are high
   function automatic logic model(input int div, input int edges);
      int hi;
      hi = div / 2 + div % 2;
      if (edges == 0) return 1'b0;
      return ((edges - 1) % div) < hi;
   endfunction

   task automatic chk(input string tag, input logic got, input logic exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s edge=%0d t=%0t got=%b expected=%b", tag, n, $time, got, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".mclk4"}, mclk4, model(4, n));
      chk({tag, ".aux8"},  aux8,  model(8, n));
      chk({tag, ".mclk5"}, mclk5, model(5, n));
      chk({tag, ".aux10"}, aux10, model(10, n));
   endtask

   task automatic run(input int edges);
      repeat (edges) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         chk_all("run");
      end
   endtask

   // Async pulse between edges, hold for some cycles, release on a falling edge
   task automatic pulse_rst(input int hold);
      #($urandom_range(1, 3));
      rst = 1'b1;
      n   = 0;
      #1;
      chk_all("async_rst");
      repeat (hold) begin
         @(negedge clk);
         chk_all("rst_hold");
      end
      rst = 1'b0;
      #1;
      chk_all("release");
   endtask

   initial begin
      #1;
      chk_all("por");
      repeat (10) begin
         @(negedge clk);
         chk_all("rst10");
      end
      rst = 1'b0;
      run(24);
      // Reset while mclk is high, right after edge 1
      pulse_rst(1);
      run(1);
      chk("mclk4_high_before_pulse", mclk4, 1'b1);
      pulse_rst(2);
      run(12);
      for (int i = 0; i < 20; i++) begin
         pulse_rst($urandom_range(1, 4));
         run($urandom_range(1, 45));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/clkdiv.md
CLKDIV -- requirements
Module: clkdiv

Interface
REQ-001 Parameter MCLK_DIV, default 4: clk cycles per mclk period (100 MHz -> 25 MHz).
REQ-002 Parameter AUX_DIV, default 50_000_000: clk cycles per aux_clk period.
REQ-003 Port clk, input, 1 bit: sole clock; all state on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port mclk, output, 1 bit: registered divided clock, period MCLK_DIV clk cycles.
REQ-006 Port aux_clk, output, 1 bit: registered divided clock, period AUX_DIV clk cycles; may be left unconnected.
REQ-007 Positional port order SHALL be rst, clk, mclk, aux_clk.

Function
REQ-008 Each output SHALL have its own divider stage with counter cnt, counting 0..DIV-1 and wrapping to 0 after DIV-1.
- Counter width is $clog2(DIV).
REQ-009 Each stage SHALL define H = ceil(DIV/2) high cycles and DIV-H low cycles.
- Even DIV gives 50% duty.
- Odd DIV is high one cycle longer than low.
REQ-010 On each clk rising edge, each stage SHALL register out <= (cnt < H), using cnt before its increment.
REQ-011 On the same edge, cnt SHALL advance: cnt <= (cnt == DIV-1) ? 0 : cnt+1.
REQ-012 Each output SHALL come straight from a flip-flop, with no combinational path from clk or rst, so it is glitch-free.
REQ-013 First rising clk edge after rst deasserts:
- both outputs go high;
- mclk stays high H_m edges, then low MCLK_DIV-H_m edges, then repeats.
REQ-014 Both stages SHALL leave reset on the same edge, so every AUX_DIV-th aux rising edge coincides with an mclk rising edge whenever AUX_DIV is a multiple of MCLK_DIV.
REQ-015 DIV < 2 for either parameter SHALL be an elaboration-time error.
REQ-016 No clock gating, no enable input, and no runtime reprogramming of divide ratios.

Reset
REQ-017 While rst=1:
- mclk=0, aux_clk=0, both counters=0;
- this takes effect immediately, independent of clk.
REQ-018 Asserting rst mid-period SHALL force both outputs low at once.
- On release, sequencing SHALL restart exactly as in REQ-013, with no partial period carried over.
REQ-019 Outputs SHALL also start at 0 at power-up (initial value matches reset value).

Structure
REQ-020 The divider SHALL be one sub-module, clkdiv_stage, parameterized by DIV, with ports clk, rst, out.
- clkdiv instantiates it twice: one for mclk, one for aux_clk.
REQ-021 Default divide constants and the H computation SHALL live in a shared package clkdiv_pkg.
- Constants: MCLK_DIV_DEFAULT=4, AUX_DIV_DEFAULT=50_000_000.
- Function: high_cycles(div).

Verification
REQ-022 Default MCLK_DIV=4: after rst release, mclk over edges 1..8 SHALL read 1,1,0,0,1,1,0,0.
REQ-023 MCLK_DIV=5: mclk SHALL read 1,1,1,0,0 repeating, i.e. 3 high / 2 low.
REQ-024 MCLK_DIV=4, AUX_DIV=8: aux_clk SHALL read 1,1,1,1,0,0,0,0, with rising edges aligned to every second mclk rising edge.
REQ-025 rst pulsed high asynchronously (between clk edges) while mclk=1: mclk SHALL drop to 0 before the next clk edge; after release, REQ-022 sequence SHALL restart from edge 1.
REQ-026 rst held 10 cycles: both outputs SHALL stay 0 throughout; MCLK_DIV=1 instantiation SHALL fail elaboration.
